// File: rtl/move_sequencer.sv
// move_sequencer: fetch/execute control sequencer for the register-move
// instructions MFHI, MFLO, MTHI and MTLO, plus NOP.
//
// Ports
//   clk                 rising-edge clock
//   clr                 asynchronous active-low reset
//   run                 level: 1 = keep fetching, 0 = stop at next boundary
//   opcode[OPW-1:0]     IR opcode field, valid from T3 onward
//   PCout..IRin         fetch controls (T0..T2)
//   Gra..LOin           execute controls (T3)
//   done                one-cycle pulse during each legal T3
//   illegal             sticky flag, set when an unsupported opcode reaches T3
//   state[3:0]          current state code (debug)
//
// Sequence: IDLE -> T0 -> T1 (1+MEM_WAIT cycles) -> T2 -> T3 -> T0/IDLE,
// with T3 -> HALT on an unsupported opcode. HALT is left only through clr.
module move_sequencer #(
    parameter int OPW      = 5,
    parameter int MEM_WAIT = 0,
    parameter logic [OPW-1:0] OP_MFHI = OPW'(5'b10000),
    parameter logic [OPW-1:0] OP_MFLO = OPW'(5'b10001),
    parameter logic [OPW-1:0] OP_MTHI = OPW'(5'b10010),
    parameter logic [OPW-1:0] OP_MTLO = OPW'(5'b10011),
    parameter logic [OPW-1:0] OP_NOP  = OPW'(5'b11010)
) (
    input  logic           clk,
    input  logic           clr,
    input  logic           run,
    input  logic [OPW-1:0] opcode,
    output logic           PCout,
    output logic           MARin,
    output logic           IncPC,
    output logic           MDRread,
    output logic           MDRin,
    output logic           MDRout,
    output logic           IRin,
    output logic           Gra,
    output logic           Rin,
    output logic           Rout,
    output logic           HIout,
    output logic           LOout,
    output logic           HIin,
    output logic           LOin,
    output logic           done,
    output logic           illegal,
    output logic [3:0]     state
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd7,
        S_T1   = 4'd8,
        S_T2   = 4'd9,
        S_T3   = 4'd10,
        S_HALT = 4'd15
    } state_e;

    localparam logic [2:0] WAIT_LOAD = 3'(MEM_WAIT);

    state_e     state_q, state_d;
    logic [2:0] wait_q, wait_d;
    logic       op_legal_s;
    logic       pcout_q, marin_q, incpc_q, mdrread_q, mdrin_q, mdrout_q, irin_q;
    logic       illegal_q;

    // Opcode legality: only meaningful while in T3.
    always_comb begin
        op_legal_s = (opcode == OP_MFHI) || (opcode == OP_MFLO) ||
                     (opcode == OP_MTHI) || (opcode == OP_MTLO) ||
                     (opcode == OP_NOP);
    end

    // Next-state and wait-counter logic.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_T0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_T0: begin
                state_d = S_T1;
                wait_d  = WAIT_LOAD;
            end
            S_T1: begin
                // Counter stops at zero on the last T1 cycle, so it never wraps.
                if (wait_q == 3'd0) begin
                    state_d = S_T2;
                    wait_d  = 3'd0;
                end else begin
                    state_d = S_T1;
                    wait_d  = wait_q - 3'd1;
                end
            end
            S_T2: begin
                state_d = S_T3;
            end
            S_T3: begin
                if (!op_legal_s) begin
                    state_d = S_HALT;
                end else if (run) begin
                    state_d = S_T0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
                wait_d  = 3'd0;
            end
        endcase
    end

    // State, wait counter, sticky illegal flag and registered fetch controls.
    // Fetch controls are registered from the next state so they line up with
    // the state they belong to and come straight out of flops.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q   <= S_IDLE;
            wait_q    <= 3'd0;
            illegal_q <= 1'b0;
            pcout_q   <= 1'b0;
            marin_q   <= 1'b0;
            incpc_q   <= 1'b0;
            mdrread_q <= 1'b0;
            mdrin_q   <= 1'b0;
            mdrout_q  <= 1'b0;
            irin_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_q || (state_d == S_HALT);
            pcout_q   <= (state_d == S_T0);
            marin_q   <= (state_d == S_T0);
            incpc_q   <= (state_d == S_T0);
            mdrread_q <= (state_d == S_T1);
            mdrin_q   <= (state_d == S_T1);
            mdrout_q  <= (state_d == S_T2);
            irin_q    <= (state_d == S_T2);
        end
    end

    // Execute controls: the opcode only becomes valid once T3 is entered, so
    // these decode the registered T3 state together with the live opcode.
    always_comb begin
        Gra   = 1'b0;
        Rin   = 1'b0;
        Rout  = 1'b0;
        HIout = 1'b0;
        LOout = 1'b0;
        HIin  = 1'b0;
        LOin  = 1'b0;
        done  = 1'b0;
        if (state_q == S_T3) begin
            done = op_legal_s;
            case (opcode)
                OP_MFHI: begin Gra = 1'b1; Rin  = 1'b1; HIout = 1'b1; end
                OP_MFLO: begin Gra = 1'b1; Rin  = 1'b1; LOout = 1'b1; end
                OP_MTHI: begin Gra = 1'b1; Rout = 1'b1; HIin  = 1'b1; end
                OP_MTLO: begin Gra = 1'b1; Rout = 1'b1; LOin  = 1'b1; end
                default: begin Gra = 1'b0; end
            endcase
        end else begin
            done = 1'b0;
        end
    end

    assign PCout   = pcout_q;
    assign MARin   = marin_q;
    assign IncPC   = incpc_q;
    assign MDRread = mdrread_q;
    assign MDRin   = mdrin_q;
    assign MDRout  = mdrout_q;
    assign IRin    = irin_q;
    assign illegal = illegal_q;
    assign state   = state_q;

endmodule
